imem_prog: RTL and testbench

IMEM_PROG -- requirements
Module: imem_prog

---
 rtl/imem_prog.sv | 102 ++++++++++
 tb/tb_imem_prog.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_prog.sv
// Loadable instruction memory: words stream in during LOAD, then RUN serves
// single-cycle-latency fetches gated by the loaded program length.
module imem_prog #(
  parameter int                ADDR_W     = 6,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] FILL_INSTR = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              load_start,
  input  logic              fetch_req,
  input  logic [ADDR_W+1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_err,
  output logic [ADDR_W:0]   prog_len
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept;
  logic              run_fetch;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_bad;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    accept     = 1'b0;
    unique case (state)
      S_LOAD: begin
        load_ready = 1'b1;
        accept     = load_valid;
        if (accept && (load_last || wr_ptr == '1)) begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (load_start) begin
          state_nx = S_LOAD;
        end
      end
      default: state_nx = S_LOAD;
    endcase
  end

  // Fetch is judged against the current prog_len, so a fetch issued together
  // with load_start still sees the program it was issued against.
  always_comb begin
    run_fetch = (state == S_RUN) && fetch_req;
    rd_idx    = fetch_addr[ADDR_W+1:2];
    rd_bad    = (fetch_addr[1:0] != 2'b00) || ({1'b0, rd_idx} >= prog_len);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_LOAD;
      wr_ptr      <= '0;
      prog_len    <= '0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_instr <= FILL_INSTR;
    end else begin
      state       <= state_nx;
      fetch_valid <= run_fetch;
      if (accept) begin
        wr_ptr   <= wr_ptr + 1'b1;
        prog_len <= prog_len + 1'b1;
      end
      if (state == S_RUN && load_start) begin
        wr_ptr   <= '0;
        prog_len <= '0;
      end
      if (run_fetch) begin
        fetch_err   <= rd_bad;
        fetch_instr <= rd_bad ? FILL_INSTR : mem[rd_idx];
      end
    end
  end

  // Array is deliberately left unreset; prog_len hides stale contents.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem[wr_ptr] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_prog.sv
// Directed self-checking bench for imem_prog: table-driven fetch vectors
// plus hand-written load/abort/reload sequences.
module tb_imem_prog;

  localparam int          ADDR_W = 6;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 2 ** ADDR_W;
  localparam logic [31:0] FILL   = 32'hdead_beef;

  logic              clk;
  logic              reset;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_start;
  logic              fetch_req;
  logic [ADDR_W+1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_err;
  logic [ADDR_W:0]   prog_len;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [ADDR_W+1:0] addr;
    logic              err;
    logic [31:0]       instr;
  } fvec_t;

  logic [31:0] prog [3];
  fvec_t       ftab [7];

  imem_prog #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .FILL_INSTR(FILL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_start (load_start),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .fetch_err  (fetch_err),
    .prog_len   (prog_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch1(input logic [ADDR_W+1:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
  endtask

  initial begin
    prog[0] = 32'h2002_0005;
    prog[1] = 32'h2003_000c;
    prog[2] = 32'h2067_fff7;
    ftab[0] = '{addr: 8'h08, err: 1'b0, instr: 32'h2067_fff7};
    ftab[1] = '{addr: 8'h00, err: 1'b0, instr: 32'h2002_0005};
    ftab[2] = '{addr: 8'h0c, err: 1'b1, instr: FILL};
    ftab[3] = '{addr: 8'h06, err: 1'b1, instr: FILL};
    ftab[4] = '{addr: 8'h01, err: 1'b1, instr: FILL};
    ftab[5] = '{addr: 8'hfc, err: 1'b1, instr: FILL};
    ftab[6] = '{addr: 8'h04, err: 1'b0, instr: 32'h2003_000c};

    reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    load_start = 1'b0; fetch_req = 1'b0; fetch_addr = '0;

    // Reset with a competing load word: reset must win.
    tick();
    load_valid = 1'b1; load_data = 32'h1234_5678; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_instr", fetch_instr, FILL);
    chk("rst_len", 32'(prog_len), 32'd0);
    reset = 1'b0;
    tick();

    // Load three words; a fetch during LOAD must be ignored.
    fetch_req = 1'b1; fetch_addr = 8'h00;
    load_word(prog[0], 1'b0);
    fetch_req = 1'b0;
    chk("load_fetch_ignored", 32'(fetch_valid), 32'd0);
    chk("load_ready_mid", 32'(load_ready), 32'd1);
    load_word(prog[1], 1'b0);
    load_word(prog[2], 1'b1);
    chk("run_ready", 32'(load_ready), 32'd0);
    chk("run_len3", 32'(prog_len), 32'd3);

    // load_valid in RUN must not alter memory or length.
    load_valid = 1'b1; load_data = 32'h1111_1111;
    tick();
    load_valid = 1'b0;
    chk("run_load_ignored_len", 32'(prog_len), 32'd3);

    // Back-to-back table fetches, one result per cycle in order.
    fetch_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      fetch_addr = ftab[i].addr;
      tick();
      chk($sformatf("tab%0d_valid", i), 32'(fetch_valid), 32'd1);
      chk($sformatf("tab%0d_err", i), 32'(fetch_err), 32'(ftab[i].err));
      chk($sformatf("tab%0d_instr", i), fetch_instr, ftab[i].instr);
    end
    fetch_req = 1'b0;
    tick();
    chk("idle_valid", 32'(fetch_valid), 32'd0);
    chk("hold_instr", fetch_instr, 32'h2003_000c);
    chk("hold_err", 32'(fetch_err), 32'd0);

    // load_start together with a fetch: fetch served, then back to LOAD.
    load_start = 1'b1; fetch_req = 1'b1; fetch_addr = 8'h04;
    tick();
    load_start = 1'b0;
    chk("ls_valid", 32'(fetch_valid), 32'd1);
    chk("ls_instr", fetch_instr, 32'h2003_000c);
    chk("ls_err", 32'(fetch_err), 32'd0);
    chk("ls_ready", 32'(load_ready), 32'd1);
    chk("ls_len", 32'(prog_len), 32'd0);
    fetch_addr = 8'h00;
    tick();
    fetch_req = 1'b0;
    chk("ls_next_fetch_ignored", 32'(fetch_valid), 32'd0);

    // Fill all DEPTH words without load_last.
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("full_ready_before_last", 32'(load_ready), 32'd1);
      load_word(32'ha000_0000 + 32'(i), 1'b0);
    end
    chk("full_ready", 32'(load_ready), 32'd0);
    chk("full_len", 32'(prog_len), 32'(DEPTH));
    fetch1(8'hfc);
    chk("full_last_valid", 32'(fetch_valid), 32'd1);
    chk("full_last_err", 32'(fetch_err), 32'd0);
    chk("full_last_instr", fetch_instr, 32'ha000_003f);
    fetch1(8'h00);
    chk("full_first_instr", fetch_instr, 32'ha000_0000);

    // Reset coincident with a fetch: no result may emerge.
    fetch_req = 1'b1; fetch_addr = 8'h04; reset = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_instr", fetch_instr, FILL);
    tick();
    chk("rst_fetch_valid2", 32'(fetch_valid), 32'd0);
    reset = 1'b0;
    tick();

    // Reset after 2 of 4 words, then a one-word reload.
    load_word(32'hb000_0000, 1'b0);
    load_word(32'hb000_0001, 1'b0);
    chk("part_len", 32'(prog_len), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("part_rst_len", 32'(prog_len), 32'd0);
    chk("part_rst_ready", 32'(load_ready), 32'd1);
    load_word(32'h0000_0055, 1'b1);
    chk("one_len", 32'(prog_len), 32'd1);
    chk("one_ready", 32'(load_ready), 32'd0);
    fetch1(8'h04);
    chk("stale_valid", 32'(fetch_valid), 32'd1);
    chk("stale_err", 32'(fetch_err), 32'd1);
    chk("stale_instr", fetch_instr, FILL);
    fetch1(8'h00);
    chk("one_err", 32'(fetch_err), 32'd0);
    chk("one_instr", fetch_instr, 32'h0000_0055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
